// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and helpers for the APB ALU execution units
package alu_pkg;

    // Error codes reported by the execution units
    localparam logic ERR_NONE      = 1'b0;
    localparam logic ERR_NEG_SHIFT = 1'b1;

    // Width of a shift index able to address every bit of an n-bit word
    function automatic int shift_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/left_shift_barrel.sv
// rtl/left_shift_barrel.sv - combinational log2(N)-stage logical left barrel shifter
module left_shift_barrel
    import alu_pkg::*;
#(
    parameter  int N   = 8,
    localparam int SHW = shift_width(N)
) (
    input  logic [N-1:0]   data,
    input  logic [SHW-1:0] amt,
    output logic [N-1:0]   shifted
);

    logic [N-1:0] stage [0:SHW];

    assign stage[0] = data;

    // Stage i shifts by 2**i when amt[i] is set; bits past N-1 fall off
    for (genvar i = 0; i < SHW; i++) begin : g_stage
        assign stage[i+1] = amt[i] ? (stage[i] << (1 << i)) : stage[i];
    end

    assign shifted = stage[SHW];

endmodule

// File: rtl/left_shift.sv
// rtl/left_shift.sv - registered signed left-shift execution unit with negative-shift error
module left_shift
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] result,
    output logic         error
);

    localparam int           SHW   = shift_width(N);
    localparam logic [N-1:0] N_VAL = N[N-1:0];

    logic           neg_shift;
    logic           over_shift;
    logic [SHW-1:0] amt;
    logic [N-1:0]   shifted;
    logic [N-1:0]   result_d;
    logic           error_d;

    // Range decode of B: sign bit marks an illegal amount, >= N clears every bit
    assign neg_shift  = B[N-1];
    assign over_shift = !neg_shift && (B >= N_VAL);
    assign amt        = B[SHW-1:0];

    left_shift_barrel #(.N(N)) u_barrel (
        .data    (A),
        .amt     (amt),
        .shifted (shifted)
    );

    always_comb begin
        result_d = '0;
        error_d  = ERR_NONE;
        if (neg_shift) begin
            error_d = ERR_NEG_SHIFT;
        end else if (!over_shift) begin
            result_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            error  <= ERR_NONE;
        end else if (en) begin
            result <= result_d;
            error  <= error_d;
        end
    end

endmodule

// File: tb/tb_left_shift.sv
// tb/tb_left_shift.sv - scoreboard testbench for left_shift with directed vectors
module tb_left_shift;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] A   = 8'h00;
    logic [7:0] B   = 8'h00;
    logic [7:0] result;
    logic       error;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t cur;

    left_shift #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .A      (A),
        .B      (B),
        .result (result),
        .error  (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: each capture edge retires one expected entry
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check({cur.name, "_result"}, result, cur.res);
            check({cur.name, "_error"}, {7'd0, error}, {7'd0, cur.err});
        end
    end

    task automatic apply(input string name, input logic e, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r, input logic er);
        exp_t x;
        @(negedge clk);
        en = e;
        A  = a;
        B  = b;
        x.name = name;
        x.res  = r;
        x.err  = er;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Asynchronous reset before the first clock edge
        A  = 8'h1A;
        B  = 8'd2;
        en = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("reset_async_result", result, 8'h00);
        check("reset_async_error", {7'd0, error}, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held_result", result, 8'h00);
        check("reset_held_error", {7'd0, error}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        apply("std_shift",    1'b1, 8'h1A, 8'd2,  8'h68, 1'b0);
        apply("neg_a",        1'b1, 8'hE6, 8'd2,  8'h98, 1'b0);
        apply("neg_b",        1'b1, 8'hE6, 8'hFD, 8'h00, 1'b1);
        apply("err_clear",    1'b1, 8'hE6, 8'd1,  8'hCC, 1'b0);
        apply("b_max",        1'b1, 8'h81, 8'd7,  8'h80, 1'b0);
        apply("b_eq_n",       1'b1, 8'h81, 8'd8,  8'h00, 1'b0);
        apply("b_zero",       1'b1, 8'h5A, 8'd0,  8'h5A, 1'b0);
        apply("b_pos_big",    1'b1, 8'hFF, 8'h7F, 8'h00, 1'b0);
        apply("b_most_neg",   1'b1, 8'hFF, 8'h80, 8'h00, 1'b1);
        apply("shift4",       1'b1, 8'hB7, 8'd4,  8'h70, 1'b0);
        apply("shift3",       1'b1, 8'h01, 8'd3,  8'h08, 1'b0);
        apply("pre_hold",     1'b1, 8'h1A, 8'd2,  8'h68, 1'b0);
        for (int i = 0; i < 3; i++)
            apply("hold",     1'b0, 8'h01, 8'd1,  8'h68, 1'b0);
        drain();

        // Reset between edges overrides en and clears immediately
        @(negedge clk);
        en = 1'b1;
        A  = 8'hFF;
        B  = 8'd1;
        #1 rst = 1'b1;
        #1;
        check("mid_reset_result", result, 8'h00);
        check("mid_reset_error", {7'd0, error}, 8'h00);
        @(posedge clk);
        #1;
        check("reset_over_en_result", result, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;

        apply("post_rst_idle", 1'b0, 8'h03, 8'd1, 8'h00, 1'b0);
        apply("post_rst_cap",  1'b1, 8'h03, 8'd1, 8'h06, 1'b0);
        apply("neg_b_again",   1'b1, 8'h03, 8'hFF, 8'h00, 1'b1);
        apply("err_hold",      1'b0, 8'h03, 8'd1, 8'h00, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
